bcd_score_counter: RTL and testbench

BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

---
 rtl/bcd_score_counter_pkg.sv | 22 ++
 rtl/bcd_score_counter_if.sv | 27 ++
 rtl/bcd_score_counter_bcd_digit_add.sv | 26 ++
 rtl/bcd_score_counter.sv | 113 +++++++++++
 tb/tb_bcd_score_counter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_score_counter_pkg.sv
// Shared constants for the BCD score counter: digit/segment widths and the
// active-low 7-segment code table.
package bcd_score_counter_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low segment codes for digits 0..9.
  localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  // Non-BCD codes cannot occur in the score, but map them to blank anyway.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_W-1:0] d);
    if (d < 4'd10) return SEG_TABLE[d];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bcd_score_counter_if.sv
// Signal bundle for the score counter.
// Handshake: there is no valid/ready pair. hit is a level; each 0->1
// transition sampled on clk is one scoring event carrying points. clear is a
// plain synchronous command. All outputs are registered or decoded from
// registered state, and overflow/new_high are single-cycle pulses.
interface bcd_score_counter_if #(
  parameter int DIGITS = 4
);
  logic                  hit;
  logic [3:0]            points;
  logic                  clear;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   high_bcd;
  logic [7*DIGITS-1:0]   hex;
  logic                  overflow;
  logic                  new_high;

  modport master (
    output hit, points, clear,
    input  score_bcd, high_bcd, hex, overflow, new_high
  );

  modport slave (
    input  hit, points, clear,
    output score_bcd, high_bcd, hex, overflow, new_high
  );
endinterface

// File: rtl/bcd_score_counter_bcd_digit_add.sv
// Single-digit BCD adder: a + b + cin, result corrected back into 0..9.
module bcd_digit_add
  import bcd_score_counter_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  logic [BCD_W:0] raw;

  // Binary add, then subtract ten and carry when the digit overflows.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    if (raw > 5'd9) begin
      sum  = BCD_W'(raw - 5'd10);
      cout = 1'b1;
    end else begin
      sum  = raw[BCD_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// BCD score counter: counts rising edges of hit, adds points (clamped to 9)
// through a ripple of BCD digit adders, tracks the high score and drives
// active-low 7-segment patterns with optional leading-zero blanking.
module bcd_score_counter
  import bcd_score_counter_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int WRAP       = 1,
  parameter int BLANK_LEAD = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hit,
  input  logic [3:0]              points,
  input  logic                    clear,
  output logic [BCD_W*DIGITS-1:0] score_bcd,
  output logic [BCD_W*DIGITS-1:0] high_bcd,
  output logic [SEG_W*DIGITS-1:0] hex,
  output logic                    overflow,
  output logic                    new_high
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic           hit_d_q, hit_d_d;
  logic [W-1:0]   score_q, score_d;
  logic [W-1:0]   high_q, high_d;
  logic           overflow_q, overflow_d;
  logic           new_high_q, new_high_d;

  logic [BCD_W-1:0] pts;
  logic [W-1:0]     sum;
  logic [DIGITS:0]  carry;
  logic             evt;
  logic             lead;
  logic [BCD_W-1:0] dig;

  // Clamp non-BCD point values to 9.
  always_comb pts = (points > 4'd9) ? 4'd9 : points;

  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_add u_add (
        .a    (score_q[gi*BCD_W +: BCD_W]),
        .b    ((gi == 0) ? pts : 4'd0),
        .cin  (carry[gi]),
        .sum  (sum[gi*BCD_W +: BCD_W]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Next-state: edge detect, score update with wrap/saturate, high-score tracking.
  always_comb begin
    evt        = hit & ~hit_d_q;
    hit_d_d    = hit;
    score_d    = score_q;
    overflow_d = 1'b0;
    if (clear) begin
      score_d = '0;
    end else if (evt && (pts != 4'd0)) begin
      if (carry[DIGITS]) begin
        overflow_d = 1'b1;
        score_d    = (WRAP != 0) ? sum : ALL_NINES;
      end else begin
        score_d = sum;
      end
    end
    // Digits are ordered MSB-first, so a plain unsigned compare orders BCD values.
    new_high_d = (score_q > high_q);
    high_d     = new_high_d ? score_q : high_q;
  end

  // State registers; hit_d resets high so a hit held through reset is ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_d_q    <= 1'b1;
      score_q    <= '0;
      high_q     <= '0;
      overflow_q <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      hit_d_q    <= hit_d_d;
      score_q    <= score_d;
      high_q     <= high_d;
      overflow_q <= overflow_d;
      new_high_q <= new_high_d;
    end
  end

  // Segment decode from the registered score, blanking zeros above the top nonzero digit.
  always_comb begin
    hex  = '0;
    lead = 1'b1;
    dig  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig = score_q[i*BCD_W +: BCD_W];
      if (dig != 4'd0) lead = 1'b0;
      if ((BLANK_LEAD != 0) && lead && (i != 0)) hex[i*SEG_W +: SEG_W] = SEG_BLANK;
      else                                        hex[i*SEG_W +: SEG_W] = seg_encode(dig);
    end
  end

  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign overflow  = overflow_q;
  assign new_high  = new_high_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench for bcd_score_counter: three instances (4-digit wrap, 4-digit
// saturate, 6-digit wrap) driven by directed steps against an integer model.
module tb_bcd_score_counter;

  logic clk;
  logic reset_n;

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance.
  int m_score  [3] = '{0, 0, 0};
  int m_high   [3] = '{0, 0, 0};
  int m_digits [3] = '{4, 4, 6};
  bit m_wrap   [3] = '{1'b1, 1'b0, 1'b1};

  // Each entry: three slots of {overflow, 24-bit score}.
  logic [74:0] exp_q[$];

  bcd_score_counter_if #(.DIGITS(4)) if0 ();
  bcd_score_counter_if #(.DIGITS(4)) if1 ();
  bcd_score_counter_if #(.DIGITS(6)) if2 ();

  bcd_score_counter #(.DIGITS(4), .WRAP(1), .BLANK_LEAD(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .hit(if0.hit), .points(if0.points), .clear(if0.clear),
    .score_bcd(if0.score_bcd), .high_bcd(if0.high_bcd), .hex(if0.hex),
    .overflow(if0.overflow), .new_high(if0.new_high)
  );

  bcd_score_counter #(.DIGITS(4), .WRAP(0), .BLANK_LEAD(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .hit(if1.hit), .points(if1.points), .clear(if1.clear),
    .score_bcd(if1.score_bcd), .high_bcd(if1.high_bcd), .hex(if1.hex),
    .overflow(if1.overflow), .new_high(if1.new_high)
  );

  bcd_score_counter #(.DIGITS(6), .WRAP(1), .BLANK_LEAD(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .hit(if2.hit), .points(if2.points), .clear(if2.clear),
    .score_bcd(if2.score_bcd), .high_bcd(if2.high_bcd), .hex(if2.hex),
    .overflow(if2.overflow), .new_high(if2.new_high)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model helpers
  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex(input int v, input int nd);
    logic [41:0] r;
    bit lead;
    int d;
    r = '0;
    lead = 1'b1;
    for (int i = nd - 1; i >= 0; i--) begin
      d = (v / (10 ** i)) % 10;
      if (d != 0) lead = 1'b0;
      if (lead && i > 0) r[i*7 +: 7] = 7'b1111111;
      else               r[i*7 +: 7] = seg_of(d);
    end
    return r;
  endfunction

  // Observation helpers
  function automatic logic [23:0] obs_score(input int k);
    case (k)
      0: return 24'(if0.score_bcd);
      1: return 24'(if1.score_bcd);
      default: return if2.score_bcd;
    endcase
  endfunction

  function automatic logic [23:0] obs_high(input int k);
    case (k)
      0: return 24'(if0.high_bcd);
      1: return 24'(if1.high_bcd);
      default: return if2.high_bcd;
    endcase
  endfunction

  function automatic logic [41:0] obs_hex(input int k);
    case (k)
      0: return 42'(if0.hex);
      1: return 42'(if1.hex);
      default: return if2.hex;
    endcase
  endfunction

  function automatic logic obs_ovf(input int k);
    case (k)
      0: return if0.overflow;
      1: return if1.overflow;
      default: return if2.overflow;
    endcase
  endfunction

  function automatic logic obs_nh(input int k);
    case (k)
      0: return if0.new_high;
      1: return if1.new_high;
      default: return if2.new_high;
    endcase
  endfunction

  // Scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic check_state(input string where);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.score%0d", where, k), 64'(obs_score(k)), 64'(to_bcd(m_score[k])));
      check($sformatf("%s.high%0d", where, k), 64'(obs_high(k)), 64'(to_bcd(m_high[k])));
      check($sformatf("%s.hex%0d", where, k), 64'(obs_hex(k)), 64'(exp_hex(m_score[k], m_digits[k])));
    end
  endtask

  task automatic drive(input logic [2:0] mask, input logic [3:0] p, input logic [2:0] clr);
    if0.hit = mask[0]; if1.hit = mask[1]; if2.hit = mask[2];
    if0.points = p;    if1.points = p;    if2.points = p;
    if0.clear = clr[0]; if1.clear = clr[1]; if2.clear = clr[2];
  endtask

  // Driver: one rising hit edge (or clear) per call, then two checking cycles.
  task automatic do_event(input logic [2:0] mask, input logic [3:0] p, input logic [2:0] clr);
    logic [74:0] ent;
    logic [24:0] slot;
    int pe, s, lim;
    logic ovf;
    bit nh;
    @(negedge clk);
    drive(mask, p, clr);
    pe = (p > 4'd9) ? 9 : int'(p);
    ent = '0;
    for (int k = 0; k < 3; k++) begin
      ovf = 1'b0;
      s = m_score[k];
      if (clr[k]) s = 0;
      else if (mask[k] && pe > 0) begin
        s = s + pe;
        lim = 10 ** m_digits[k];
        if (s >= lim) begin
          ovf = 1'b1;
          s = m_wrap[k] ? s - lim : lim - 1;
        end
      end
      m_score[k] = s;
      ent[k*25 +: 25] = {ovf, to_bcd(s)};
    end
    exp_q.push_back(ent);
    @(negedge clk);
    ent = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      slot = ent[k*25 +: 25];
      check($sformatf("score%0d", k), 64'(obs_score(k)), 64'(slot[23:0]));
      check($sformatf("overflow%0d", k), 64'(obs_ovf(k)), 64'(slot[24]));
    end
    drive(3'b000, p, 3'b000);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nh = (m_score[k] > m_high[k]);
      if (nh) m_high[k] = m_score[k];
      check($sformatf("overflow_end%0d", k), 64'(obs_ovf(k)), 64'd0);
      check($sformatf("high%0d", k), 64'(obs_high(k)), 64'(to_bcd(m_high[k])));
      check($sformatf("new_high%0d", k), 64'(obs_nh(k)), 64'(nh));
    end
  endtask

  // Directed sequence
  initial begin
    reset_n = 1'b0;
    drive(3'b000, 4'd0, 3'b000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_state("reset");
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset.overflow%0d", k), 64'(obs_ovf(k)), 64'd0);
      check($sformatf("reset.new_high%0d", k), 64'(obs_nh(k)), 64'd0);
    end

    // Count 1 per pulse up to 9, then carry into digit 1.
    repeat (9) do_event(3'b111, 4'd1, 3'b000);
    check_state("nine");
    do_event(3'b111, 4'd1, 3'b000);
    check_state("ten");
    check("ten.hex_digit1", 64'(if0.hex[13:7]), 64'(7'b1111001));

    // Held-high hit counts exactly once.
    @(negedge clk);
    drive(3'b111, 4'd5, 3'b000);
    for (int k = 0; k < 3; k++) m_score[k] = m_score[k] + 5;
    repeat (20) begin
      @(negedge clk);
      check("hold.score0", 64'(obs_score(0)), 64'(to_bcd(m_score[0])));
    end
    drive(3'b000, 4'd5, 3'b000);
    for (int k = 0; k < 3; k++) if (m_score[k] > m_high[k]) m_high[k] = m_score[k];
    @(negedge clk);
    check_state("hold");

    // Out-of-range points clamp to 9; zero points change nothing.
    do_event(3'b111, 4'd12, 3'b000);
    do_event(3'b111, 4'd0, 3'b000);

    // Climb to 0420, then clear together with a hit.
    repeat (44) do_event(3'b111, 4'd9, 3'b000);
    check_state("s420");
    do_event(3'b111, 4'd5, 3'b111);
    check_state("clear");
    check("clear.high0", 64'(if0.high_bcd), 64'h0420);

    // Climb to 305 and check blanking on the 6-digit instance.
    repeat (33) do_event(3'b111, 4'd9, 3'b000);
    do_event(3'b111, 4'd8, 3'b000);
    check_state("s305");
    check("s305.blank543", 64'(if2.hex[41:21]), 64'({3{7'b1111111}}));
    check("s305.digit1", 64'(if2.hex[13:7]), 64'(7'b1000000));

    // Climb to 9995 everywhere.
    repeat (1076) do_event(3'b111, 4'd9, 3'b000);
    do_event(3'b111, 4'd6, 3'b000);
    check_state("s9995");

    // Wrap instance: 9998 + 3 wraps to 0001, high stays 9998.
    do_event(3'b001, 4'd3, 3'b000);
    do_event(3'b001, 4'd3, 3'b000);
    check("wrap.score0", 64'(if0.score_bcd), 64'h0001);
    check("wrap.high0", 64'(if0.high_bcd), 64'h9998);

    // Saturating instance: 9995 + 7 then + 2 both hold 9999 and overflow.
    do_event(3'b010, 4'd7, 3'b000);
    do_event(3'b010, 4'd2, 3'b000);
    check("sat.score1", 64'(if1.score_bcd), 64'h9999);
    check_state("sat");

    // Reset with a rising hit: the add is dropped and the held hit does not count.
    @(negedge clk);
    reset_n = 1'b0;
    drive(3'b111, 4'd5, 3'b000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_score[k] = 0;
      m_high[k] = 0;
    end
    repeat (3) @(negedge clk);
    check_state("rst_hold");
    drive(3'b000, 4'd5, 3'b000);
    do_event(3'b111, 4'd2, 3'b000);
    check_state("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
